regfile_writeback_arbiter: RTL

- Producer-side counterpart of the register file write port.
- Collects writeback results from two execution sources (ALU, load unit) over valid/ready handshakes and buffers them in a small FIFO.
- Drains the FIFO, one entry per cycle, onto the register file's write_en/write_addr/write_data port.
- Reports whether a register still has a write in flight, so decode can stall reads of that register.

---
 rtl/regfile_writeback_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results into a small FIFO and drains
// one entry per cycle onto the register file write port.
module regfile_writeback_arbiter #(
    parameter int WORDSIZE = 64,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_addr,
    input  logic [WORDSIZE-1:0]       alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [4:0]                mem_addr,
    input  logic [WORDSIZE-1:0]       mem_data,
    output logic                      rf_write_en,
    output logic [4:0]                rf_write_addr,
    output logic [WORDSIZE-1:0]       rf_write_data,
    input  logic [4:0]                qry_addr,
    output logic                      qry_pending,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {SRC_ALU, SRC_MEM} src_e;

    src_e                lastGrant_q, lastGrant_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [PW:0]         count_q, count_d;
    logic [4:0]          addrMem_q [DEPTH];
    logic [WORDSIZE-1:0] dataMem_q [DEPTH];
    logic                rfEn_q;
    logic [4:0]          rfAddr_q;
    logic [WORDSIZE-1:0] rfData_q;

    logic                full;
    logic                aluGnt;
    logic                memGnt;
    logic                push;
    logic                pop;
    logic [4:0]          pushAddr;
    logic [WORDSIZE-1:0] pushData;
    logic [PW-1:0]       slotOffset;

    // Ready is gated by rst_n so no handshake completes while reset is held.
    always_comb begin
        full        = (count_q == (PW+1)'(DEPTH));
        aluGnt      = 1'b0;
        memGnt      = 1'b0;
        if (rst_n && !full) begin
            if (alu_valid && mem_valid) begin
                if (lastGrant_q == SRC_ALU) begin
                    memGnt = 1'b1;
                end else begin
                    aluGnt = 1'b1;
                end
            end else begin
                aluGnt = alu_valid;
                memGnt = mem_valid;
            end
        end
        pushAddr    = memGnt ? mem_addr : alu_addr;
        pushData    = memGnt ? mem_data : alu_data;
        push        = (aluGnt || memGnt) && (pushAddr != 5'd0);
        pop         = (count_q != '0);
        lastGrant_d = lastGrant_q;
        if (aluGnt) begin
            lastGrant_d = SRC_ALU;
        end else if (memGnt) begin
            lastGrant_d = SRC_MEM;
        end
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q <= SRC_ALU;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rfEn_q      <= 1'b0;
            rfAddr_q    <= '0;
            rfData_q    <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rfEn_q      <= pop;
            if (pop) begin
                rfAddr_q <= addrMem_q[head_q];
                rfData_q <= dataMem_q[head_q];
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[tail_q] <= pushAddr;
            dataMem_q[tail_q] <= pushData;
        end
    end

    always_comb begin
        qry_pending = rfEn_q && (rfAddr_q == qry_addr);
        slotOffset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slotOffset = PW'(i) - head_q;
            if (({1'b0, slotOffset} < count_q) && (addrMem_q[i] == qry_addr)) begin
                qry_pending = 1'b1;
            end
        end
        if (qry_addr == 5'd0) begin
            qry_pending = 1'b0;
        end
    end

    assign alu_ready     = aluGnt;
    assign mem_ready     = memGnt;
    assign rf_write_en   = rfEn_q;
    assign rf_write_addr = rfAddr_q;
    assign rf_write_data = rfData_q;
    assign count         = count_q;

endmodule
